// File: rtl/quat_pkg.sv
// Shared types and constants for the quaternion add/sub scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package quat_pkg;

    localparam int COMP_W   = 16;
    localparam int NUM_COMP = 4;
    localparam int QUAT_W   = COMP_W * NUM_COMP;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } sched_state_t;

endpackage

// File: rtl/addsub_quat.sv
// FP16 quaternion add/subtract, component-wise {w,i,j,k}, round-to-nearest-even.
// Latency: combinational.
// Backpressure: none; the caller holds operands stable until it captures y.
module addsub_quat
    import quat_pkg::*;
(
    input  logic [QUAT_W-1:0] a,
    input  logic [QUAT_W-1:0] b,
    input  logic              op,
    output logic [QUAT_W-1:0] y
);

    // One FP16 addition; subtraction is done by the caller flipping b's sign.
    function automatic logic [15:0] fp16_add(input logic [15:0] fa, input logic [15:0] fb);
        logic [15:0] x, yv;
        logic [5:0]  ex, ey, e;
        logic [13:0] mx, my, n;
        logic [63:0] sh;
        logic [14:0] s;
        logic [11:0] m;
        logic        rnd, a_nan, b_nan, a_inf, b_inf;
        a_nan = (fa[14:10] == 5'h1F) && (fa[9:0] != 10'd0);
        b_nan = (fb[14:10] == 5'h1F) && (fb[9:0] != 10'd0);
        a_inf = (fa[14:10] == 5'h1F) && (fa[9:0] == 10'd0);
        b_inf = (fb[14:10] == 5'h1F) && (fb[9:0] == 10'd0);
        if (a_nan || b_nan || (a_inf && b_inf && (fa[15] != fb[15])))
            return 16'h7E00;
        if (a_inf) return fa;
        if (b_inf) return fb;
        // Larger magnitude goes to x so the aligned difference never goes negative.
        if (fa[14:0] >= fb[14:0]) begin
            x = fa; yv = fb;
        end else begin
            x = fb; yv = fa;
        end
        ex = (x[14:10] == 5'd0)  ? 6'd1 : {1'b0, x[14:10]};
        ey = (yv[14:10] == 5'd0) ? 6'd1 : {1'b0, yv[14:10]};
        mx = {x[14:10] != 5'd0, x[9:0], 3'b000};
        my = {yv[14:10] != 5'd0, yv[9:0], 3'b000};
        // Align y, folding everything shifted out into the sticky bit.
        sh = {my, 50'd0} >> (ex - ey);
        my = {sh[63:51], sh[50] | (|sh[49:0])};
        s  = (x[15] ^ yv[15]) ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});
        if (s == 15'd0) return 16'h0000;
        e = ex;
        if (s[14]) begin
            n = {s[14:2], s[1] | s[0]};
            e = e + 6'd1;
        end else begin
            n = s[13:0];
        end
        // Normalise left, stopping at the subnormal exponent.
        for (int i = 0; i < 13; i++) begin
            if (!n[13] && (e > 6'd1)) begin
                n = n << 1;
                e = e - 6'd1;
            end
        end
        rnd = n[2] & (n[1] | n[0] | n[3]);
        m   = {1'b0, n[13:3]} + {11'd0, rnd};
        if (m[11]) begin
            m = m >> 1;
            e = e + 6'd1;
        end
        if (e >= 6'd31) return {x[15], 5'h1F, 10'd0};
        return {x[15], (m[10] ? e[4:0] : 5'd0), m[9:0]};
    endfunction

    logic [COMP_W-1:0] comp_b;

    // Apply the op to each component independently.
    always_comb begin
        y      = '0;
        comp_b = '0;
        for (int c = 0; c < NUM_COMP; c++) begin
            comp_b     = b[c*COMP_W +: COMP_W];
            comp_b[15] = comp_b[15] ^ (op == OP_SUB);
            y[c*COMP_W +: COMP_W] = fp16_add(a[c*COMP_W +: COMP_W], comp_b);
        end
    end

endmodule

// File: rtl/quat_addsub_sched.sv
// Round-robin share of one addsub_quat between NUM_REQ requesters; optional QUAT_SCHED_STATS_EN counters.
// Latency: accept edge T -> rsp_valid in cycle T+LAT+1; one op in flight, issue interval LAT+2.
// Backpressure: req_ready only in IDLE for the RR winner; RESP holds rsp_valid/rsp_data until rsp_ready.
module quat_addsub_sched
    import quat_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LAT     = 1
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_op,
    input  logic [QUAT_W*NUM_REQ-1:0] req_a,
    input  logic [QUAT_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [QUAT_W-1:0]         rsp_data
`ifdef QUAT_SCHED_STATS_EN
    ,
    output logic [15:0]               stat_ops,
    output logic [31:0]               stat_busy
`endif
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    sched_state_t      state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     grant;
    logic [CW-1:0]     cnt;
    logic [QUAT_W-1:0] a_q;
    logic [QUAT_W-1:0] b_q;
    logic              op_q;
    logic [QUAT_W-1:0] dp_y;
    logic              win_found;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     ptr_next;

    // Round-robin search from ptr: first valid requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_valid[(int'(ptr) + i) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = PW'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

    assign ptr_next = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);

    // Ready for the winner only, and never while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state == ST_IDLE) && win_found)
            req_ready[win_idx] = 1'b1;
    end

    // Response valid goes only to the requester that owns the in-flight op.
    always_comb begin
        rsp_valid = '0;
        if (state == ST_RESP)
            rsp_valid[grant] = 1'b1;
    end

    // Scheduler FSM: arbitrate, wait out the datapath, hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            grant    <= '0;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            rsp_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        grant <= win_idx;
                        ptr   <= ptr_next;
                        a_q   <= req_a[int'(win_idx)*QUAT_W +: QUAT_W];
                        b_q   <= req_b[int'(win_idx)*QUAT_W +: QUAT_W];
                        op_q  <= req_op[win_idx];
                        cnt   <= '0;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt == CW'(LAT - 1)) begin
                        rsp_data <= dp_y;
                        cnt      <= '0;
                        state    <= ST_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready[grant])
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    addsub_quat u_addsub (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (dp_y)
    );

`ifdef QUAT_SCHED_STATS_EN
    // Completed handshakes (wrapping) and non-idle cycles (saturating).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops  <= '0;
            stat_busy <= '0;
        end else begin
            if ((state == ST_RESP) && rsp_ready[grant])
                stat_ops <= stat_ops + 16'd1;
            if ((state != ST_IDLE) && (stat_busy != 32'hFFFF_FFFF))
                stat_busy <= stat_busy + 32'd1;
        end
    end
`endif

endmodule
